// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_if
//  Brief    : Operation/result bundle between ID/EX and the alu_exec stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             valid_i;
  logic [5:0]       opcode_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [SHW-1:0]   shamt_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             illegal_o;
  logic [3:0]       aluop_o;

  modport master (
    output valid_i, opcode_i, funct_i, a_i, b_i, shamt_i,
    input  ready_o, busy_o, done_o, result_o, zero_o, illegal_o, aluop_o
  );

  modport slave (
    input  valid_i, opcode_i, funct_i, a_i, b_i, shamt_i,
    output ready_o, busy_o, done_o, result_o, zero_o, illegal_o, aluop_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec
//  Brief    : Registered MIPS EX-stage ALU with opcode/funct decode and an
//             optional iterative multiply/divide engine (macro ALU_MULDIV_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_exec_if.slave bus
);

  localparam logic [3:0] c_OP_AND  = 4'd0;
  localparam logic [3:0] c_OP_OR   = 4'd1;
  localparam logic [3:0] c_OP_ADD  = 4'd2;
  localparam logic [3:0] c_OP_SLL  = 4'd3;
  localparam logic [3:0] c_OP_SRL  = 4'd4;
  localparam logic [3:0] c_OP_SRA  = 4'd5;
  localparam logic [3:0] c_OP_SUB  = 4'd6;
  localparam logic [3:0] c_OP_SLT  = 4'd7;
  localparam logic [3:0] c_OP_XOR  = 4'd8;
  localparam logic [3:0] c_OP_NOR  = 4'd9;
  localparam logic [3:0] c_OP_SLTU = 4'd10;
  localparam logic [3:0] c_OP_LUI  = 4'd11;
  localparam logic [3:0] c_OP_ILL  = 4'd15;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] c_OP_MD   = 4'd12;
  localparam logic [3:0] c_OP_MFHI = 4'd13;
  localparam logic [3:0] c_OP_MFLO = 4'd14;
  localparam logic [SHW-1:0] c_CNT_INIT = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;
  state_t           r_state;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_wh, r_wl, r_op, r_a;
  logic             r_ismul, r_negq, r_negr, r_divz;
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_maga, w_magb, w_addend, w_dhi, w_dlo, w_nh, w_nl, w_fh, w_fl;
  logic [WIDTH:0]   w_msum, w_rr, w_rsub;
  logic             w_dge;
  logic [2*WIDTH-1:0] w_mnext, w_prod, w_prodf;
`endif

  logic             w_var, w_ready, w_accept;
  logic [3:0]       w_aluop;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_done, r_illegal;
  logic [3:0]       r_aluop;

  always_comb begin
    w_aluop = c_OP_ILL;
    w_var   = 1'b0;
    case (bus.opcode_i)
      6'h00: begin
        case (bus.funct_i)
          6'h00: w_aluop = c_OP_SLL;
          6'h02: w_aluop = c_OP_SRL;
          6'h03: w_aluop = c_OP_SRA;
          6'h04: begin w_aluop = c_OP_SLL; w_var = 1'b1; end
          6'h06: begin w_aluop = c_OP_SRL; w_var = 1'b1; end
          6'h07: begin w_aluop = c_OP_SRA; w_var = 1'b1; end
          6'h20, 6'h21: w_aluop = c_OP_ADD;
          6'h22, 6'h23: w_aluop = c_OP_SUB;
          6'h24: w_aluop = c_OP_AND;
          6'h25: w_aluop = c_OP_OR;
          6'h26: w_aluop = c_OP_XOR;
          6'h27: w_aluop = c_OP_NOR;
          6'h2A: w_aluop = c_OP_SLT;
          6'h2B: w_aluop = c_OP_SLTU;
`ifdef ALU_MULDIV_EN
          6'h10: w_aluop = c_OP_MFHI;
          6'h12: w_aluop = c_OP_MFLO;
          6'h18, 6'h19, 6'h1A, 6'h1B: w_aluop = c_OP_MD;
`endif
          default: w_aluop = c_OP_ILL;
        endcase
      end
      6'h23, 6'h2B, 6'h08, 6'h09: w_aluop = c_OP_ADD;
      6'h04, 6'h05: w_aluop = c_OP_SUB;
      6'h0A: w_aluop = c_OP_SLT;
      6'h0B: w_aluop = c_OP_SLTU;
      6'h0C: w_aluop = c_OP_AND;
      6'h0D: w_aluop = c_OP_OR;
      6'h0E: w_aluop = c_OP_XOR;
      6'h0F: w_aluop = c_OP_LUI;
      default: w_aluop = c_OP_ILL;
    endcase
  end

  assign w_sh = w_var ? bus.a_i[SHW-1:0] : bus.shamt_i;

  always_comb begin
    w_res = '0;
    case (w_aluop)
      c_OP_AND:  w_res = bus.a_i & bus.b_i;
      c_OP_OR:   w_res = bus.a_i | bus.b_i;
      c_OP_ADD:  w_res = bus.a_i + bus.b_i;
      c_OP_SLL:  w_res = bus.b_i << w_sh;
      c_OP_SRL:  w_res = bus.b_i >> w_sh;
      c_OP_SRA:  w_res = $unsigned($signed(bus.b_i) >>> w_sh);
      c_OP_SUB:  w_res = bus.a_i - bus.b_i;
      c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(bus.a_i) < $signed(bus.b_i)};
      c_OP_XOR:  w_res = bus.a_i ^ bus.b_i;
      c_OP_NOR:  w_res = ~(bus.a_i | bus.b_i);
      c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, bus.a_i < bus.b_i};
      c_OP_LUI:  w_res = bus.b_i << 16;
`ifdef ALU_MULDIV_EN
      c_OP_MFHI: w_res = r_hi;
      c_OP_MFLO: w_res = r_lo;
`endif
      default:   w_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  assign w_ready = (r_state == S_IDLE);

  // Operands are reduced to magnitudes at load; signs are reapplied at the end.
  assign w_sa   = ~bus.funct_i[0] & bus.a_i[WIDTH-1];
  assign w_sb   = ~bus.funct_i[0] & bus.b_i[WIDTH-1];
  assign w_maga = w_sa ? -bus.a_i : bus.a_i;
  assign w_magb = w_sb ? -bus.b_i : bus.b_i;

  always_comb begin
    w_addend = r_wl[0] ? r_op : '0;
    w_msum   = {1'b0, r_wh} + {1'b0, w_addend};
    w_mnext  = {w_msum, r_wl[WIDTH-1:1]};
    w_rr     = {r_wh, r_wl[WIDTH-1]};
    w_dge    = (w_rr >= {1'b0, r_op});
    w_rsub   = w_rr - {1'b0, r_op};
    w_dhi    = w_dge ? w_rsub[WIDTH-1:0] : w_rr[WIDTH-1:0];
    w_dlo    = {r_wl[WIDTH-2:0], w_dge};
    w_nh     = r_ismul ? w_mnext[2*WIDTH-1:WIDTH] : w_dhi;
    w_nl     = r_ismul ? w_mnext[WIDTH-1:0]       : w_dlo;
    w_prod   = {w_nh, w_nl};
    w_prodf  = r_negq ? -w_prod : w_prod;
    if (r_ismul) begin
      w_fh = w_prodf[2*WIDTH-1:WIDTH];
      w_fl = w_prodf[WIDTH-1:0];
    end else if (r_divz) begin
      w_fh = r_a;
      w_fl = '1;
    end else begin
      w_fh = r_negr ? -w_nh : w_nh;
      w_fl = r_negq ? -w_nl : w_nl;
    end
  end
`else
  assign w_ready = 1'b1;
`endif

  assign w_accept = bus.valid_i & w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_aluop   <= '0;
`ifdef ALU_MULDIV_EN
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_wh      <= '0;
      r_wl      <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_ismul   <= 1'b0;
      r_negq    <= 1'b0;
      r_negr    <= 1'b0;
      r_divz    <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      if (w_accept) begin
        r_aluop <= w_aluop;
        if (w_aluop == c_OP_ILL) begin
          r_result  <= '0;
          r_zero    <= 1'b0;
          r_illegal <= 1'b1;
        end
`ifdef ALU_MULDIV_EN
        else if (w_aluop == c_OP_MD) begin
          r_state <= S_RUN;
          r_cnt   <= c_CNT_INIT;
          r_wh    <= '0;
          r_wl    <= w_maga;
          r_op    <= w_magb;
          r_a     <= bus.a_i;
          r_ismul <= ~bus.funct_i[1];
          r_negq  <= w_sa ^ w_sb;
          r_negr  <= w_sa;
          r_divz  <= bus.funct_i[1] & (bus.b_i == '0);
        end
`endif
        else begin
          r_result <= w_res;
          r_zero   <= (w_res == '0);
          r_done   <= 1'b1;
        end
      end
`ifdef ALU_MULDIV_EN
      case (r_state)
        S_RUN: begin
          r_wh  <= w_nh;
          r_wl  <= w_nl;
          r_cnt <= r_cnt - 1'b1;
          // Last iteration also commits HI/LO and presents LO on the result.
          if (r_cnt == '0) begin
            r_hi     <= w_fh;
            r_lo     <= w_fl;
            r_result <= w_fl;
            r_zero   <= (w_fl == '0);
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: ;
      endcase
`endif
    end
  end

  assign bus.ready_o   = w_ready;
  assign bus.busy_o    = ~w_ready;
  assign bus.done_o    = r_done;
  assign bus.result_o  = r_result;
  assign bus.zero_o    = r_zero;
  assign bus.illegal_o = r_illegal;
  assign bus.aluop_o   = r_aluop;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec
//  Brief    : Directed self-checking bench for alu_exec.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(WIDTH)) bus ();
  alu_exec #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    bus.valid_i  = 1'b1;
    bus.opcode_i = opc;
    bus.funct_i  = fn;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.shamt_i  = sh;
  endtask

  // Presents one op for one edge; returns #1 after that edge.
  task automatic op1(input logic [5:0] opc, input logic [5:0] fn,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    @(negedge clk);
    drive(opc, fn, a, b, sh);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic md_run(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output int nb, output int di, output logic [31:0] res);
    op1(6'h00, fn, a, b, 5'd0);
    nb = 0; di = 0; res = '0;
    for (int k = 1; k <= 100; k++) begin
      if (bus.done_o) begin di = k; res = bus.result_o; end
      if (!bus.busy_o) break;
      nb++;
      @(posedge clk); #1;
    end
  endtask

  int          nb, di, ndone, add_idx;
  logic [31:0] res, first_res, second_res;

  initial begin
    bus.valid_i = 1'b0; bus.opcode_i = '0; bus.funct_i = '0;
    bus.a_i = '0; bus.b_i = '0; bus.shamt_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",   32'(bus.ready_o),   32'd1);
    check("rst_busy",    32'(bus.busy_o),    32'd0);
    check("rst_done",    32'(bus.done_o),    32'd0);
    check("rst_result",  bus.result_o,       32'd0);
    check("rst_illegal", 32'(bus.illegal_o), 32'd0);
    check("rst_aluop",   32'(bus.aluop_o),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op1(6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 5'd0);
    check("add_res",  bus.result_o,    32'h80000000);
    check("add_done", 32'(bus.done_o), 32'd1);
    check("add_zero", 32'(bus.zero_o), 32'd0);
    op1(6'h00, 6'h22, 32'd5, 32'd5, 5'd0);
    check("sub_res",   bus.result_o,     32'd0);
    check("sub_zero",  32'(bus.zero_o),  32'd1);
    check("sub_aluop", 32'(bus.aluop_o), 32'd6);
    check("sub_done",  32'(bus.done_o),  32'd1);
    op1(6'h00, 6'h03, 32'd0, 32'hF0000000, 5'd4);
    check("sra_res", bus.result_o, 32'hFF000000);
    op1(6'h00, 6'h06, 32'd36, 32'hF0000000, 5'd0);
    check("srlv_res", bus.result_o, 32'h0F000000);
    op1(6'h00, 6'h00, 32'd0, 32'h00000003, 5'd31);
    check("sll_res", bus.result_o, 32'h80000000);
    op1(6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 5'd0);
    check("slt_res", bus.result_o, 32'd1);
    op1(6'h00, 6'h2B, 32'hFFFFFFFF, 32'd1, 5'd0);
    check("sltu_res", bus.result_o, 32'd0);
    op1(6'h0F, 6'h00, 32'd0, 32'h00001234, 5'd0);
    check("lui_res",   bus.result_o,     32'h12340000);
    check("lui_aluop", 32'(bus.aluop_o), 32'd11);
    op1(6'h00, 6'h27, 32'd0, 32'd0, 5'd0);
    check("nor_res", bus.result_o, 32'hFFFFFFFF);
    op1(6'h0E, 6'h00, 32'h0000F0F0, 32'h0000FF00, 5'd0);
    check("xori_res", bus.result_o, 32'h00000FF0);
    op1(6'h23, 6'h00, 32'h00001000, 32'hFFFFFFFC, 5'd0);
    check("lw_addr", bus.result_o, 32'h00000FFC);
    op1(6'h05, 6'h00, 32'd9, 32'd9, 5'd0);
    check("bne_zero", 32'(bus.zero_o), 32'd1);
    @(posedge clk); #1;
    check("done_drop", 32'(bus.done_o), 32'd0);

    op1(6'h00, 6'h3F, 32'd1, 32'd2, 5'd0);
    check("ill_flag", 32'(bus.illegal_o), 32'd1);
    check("ill_done", 32'(bus.done_o),    32'd0);
    check("ill_res",  bus.result_o,       32'd0);
    @(posedge clk); #1;
    check("ill_drop", 32'(bus.illegal_o), 32'd0);

`ifdef ALU_MULDIV_EN
    md_run(6'h18, 32'hFFFFFFFD, 32'd7, nb, di, res);
    check("mult_busy", 32'(nb), 32'd33);
    check("mult_done", 32'(di), 32'd33);
    check("mult_lo",   res,     32'hFFFFFFEB);
    op1(6'h00, 6'h10, 32'd0, 32'd0, 5'd0);
    check("mfhi_mult", bus.result_o, 32'hFFFFFFFF);
    op1(6'h00, 6'h12, 32'd0, 32'd0, 5'd0);
    check("mflo_mult", bus.result_o, 32'hFFFFFFEB);

    md_run(6'h1A, 32'hFFFFFFF9, 32'd2, nb, di, res);
    check("div_lo", res, 32'hFFFFFFFD);
    op1(6'h00, 6'h10, 32'd0, 32'd0, 5'd0);
    check("div_hi", bus.result_o, 32'hFFFFFFFF);

    md_run(6'h1B, 32'd9, 32'd0, nb, di, res);
    check("divz_lo", res, 32'hFFFFFFFF);
    op1(6'h00, 6'h10, 32'd0, 32'd0, 5'd0);
    check("divz_hi", bus.result_o, 32'd9);

    md_run(6'h1A, 32'h80000000, 32'hFFFFFFFF, nb, di, res);
    check("divovf_lo", res, 32'h80000000);
    op1(6'h00, 6'h10, 32'd0, 32'd0, 5'd0);
    check("divovf_hi", bus.result_o, 32'd0);

    md_run(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, nb, di, res);
    check("multu_lo", res, 32'h00000001);
    op1(6'h00, 6'h10, 32'd0, 32'd0, 5'd0);
    check("multu_hi", bus.result_o, 32'hFFFFFFFE);

    // ADD held on valid_i across a MULTU; it must wait for ready_o.
    op1(6'h00, 6'h19, 32'd3, 32'd4, 5'd0);
    drive(6'h00, 6'h20, 32'd2, 32'd3, 5'd0);
    ndone = 0; add_idx = 0; first_res = '0; second_res = '0;
    for (int k = 1; k <= 45; k++) begin
      if (bus.done_o) begin
        ndone++;
        if (ndone == 1) first_res = bus.result_o;
        if (ndone == 2) begin second_res = bus.result_o; add_idx = k; bus.valid_i = 1'b0; end
      end
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    check("hold_ndone", 32'(ndone),   32'd2);
    check("hold_mul",   first_res,    32'd12);
    check("hold_add",   second_res,   32'd5);
    check("hold_idx",   32'(add_idx), 32'd35);

    op1(6'h00, 6'h1B, 32'd100, 32'd3, 5'd0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ready",  32'(bus.ready_o), 32'd1);
    check("arst_busy",   32'(bus.busy_o),  32'd0);
    check("arst_done",   32'(bus.done_o),  32'd0);
    check("arst_result", bus.result_o,     32'd0);
    check("arst_aluop",  32'(bus.aluop_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done_o) ndone++;
    end
    check("arst_nodone", 32'(ndone), 32'd0);
    op1(6'h00, 6'h12, 32'd0, 32'd0, 5'd0);
    check("arst_mflo", bus.result_o, 32'd0);
    check("arst_mflo_done", 32'(bus.done_o), 32'd1);
`else
    op1(6'h00, 6'h18, 32'hFFFFFFFD, 32'd7, 5'd0);
    check("nomd_ill",  32'(bus.illegal_o), 32'd1);
    check("nomd_done", 32'(bus.done_o),    32'd0);
    check("nomd_busy", 32'(bus.busy_o),    32'd0);
    op1(6'h00, 6'h10, 32'd0, 32'd0, 5'd0);
    check("nomd_mfhi", 32'(bus.illegal_o), 32'd1);
    check("nomd_rdy",  32'(bus.ready_o),   32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_exec.md
# alu_exec

Parametrised, registered MIPS execute-stage ALU with integrated control decode. It decodes opcode/funct into an internal 4-bit ALU operation, evaluates single-cycle operations with one registered cycle of latency, and runs an iterative multiply/divide engine that writes HI/LO. It sits in the EX stage: operands come from ID/EX, results go to EX/MEM, and `busy_o` stalls upstream while a multiply or divide runs.

## Interface
- `WIDTH`, 32: datapath width; must be at least 17 (`lui` shifts by 16); multiply/divide takes `WIDTH` iteration cycles.
- `SHW`, `$clog2(WIDTH)`: shift-amount width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  an operation is presented this cycle.
- `opcode_i`  in  6  MIPS opcode.
- `funct_i`  in  6  MIPS funct; used only when `opcode_i` is 0.
- `a_i`  in  WIDTH  rs operand.
- `b_i`  in  WIDTH  rt operand, or the immediate (already extended upstream).
- `shamt_i`  in  SHW  shift amount for `sll`/`srl`/`sra`.
- `ready_o`  out  1  able to accept an operation; equals `!busy_o`.
- `busy_o`  out  1  multiply/divide in progress.
- `done_o`  out  1  one-cycle pulse: `result_o` is valid.
- `result_o`  out  WIDTH  registered result.
- `zero_o`  out  1  registered; high when the ALU result is 0.
- `illegal_o`  out  1  one-cycle pulse: the opcode/funct was not decoded.
- `aluop_o`  out  4  registered decoded operation, for debug/trace.

## Operation
- ALU operation codes: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 SRA, 6 SUB, 7 SLT, 8 XOR, 9 NOR, 10 SLTU, 11 LUI, 12 MD (multiply/divide), 13 MFHI, 14 MFLO, 15 illegal.
- Opcode decode: 0x23/0x2B/0x08/0x09 → ADD; 0x04/0x05 → SUB; 0x0A → SLT; 0x0B → SLTU; 0x0C → AND; 0x0D → OR; 0x0E → XOR; 0x0F → LUI (`b_i << 16`).
- Funct decode (opcode 0):
  - 0x00 SLL, 0x02 SRL, 0x03 SRA: shift `b_i` by `shamt_i`.
  - 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: shift `b_i` by `a_i[SHW-1:0]`.
  - 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A SLT; 0x2B SLTU.
  - 0x10 MFHI, 0x12 MFLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
- Anything else: `illegal_o` pulses, `result_o` = 0, `done_o` = 0.
- Arithmetic wraps modulo 2^WIDTH; no overflow trap. SLT compares signed, SLTU unsigned; both yield 1 or 0.
- Multiply/divide state machine: IDLE → RUN → FIN → IDLE.
  - RUN lasts exactly `WIDTH` cycles, driven by a down-counter.
  - Multiply uses shift-add on operand magnitudes: `{HI,LO}` = full 2·WIDTH-bit product.
  - Divide uses restoring division on magnitudes: LO = quotient, HI = remainder.
  - Signed forms (MULT, DIV): quotient/product sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Divide by zero: LO = all ones, HI = `a_i`. No exception.
  - Signed divide of the most negative value by −1: LO = the most negative value, HI = 0.
- HI and LO update only in FIN. MFHI/MFLO read the committed HI/LO.

## Timing
- An operation is accepted when `valid_i` and `ready_o` are both high. `valid_i` while busy is ignored; upstream must hold the operation.
- Single-cycle operation accepted at cycle T:
  - `result_o`, `zero_o`, `aluop_o` update at T+1;
  - `done_o` pulses at T+1.
  - Back-to-back operations on every cycle are supported.
- MULT/DIV family accepted at T:
  - `busy_o` is high from T+1 through T+WIDTH+1;
  - HI/LO are written at the T+WIDTH+1 edge;
  - `done_o` pulses at T+WIDTH+1 with `result_o` = new LO;
  - `ready_o` returns high at T+WIDTH+2.
- An MFHI/MFLO accepted at T+WIDTH+2 therefore sees the new value.
- Reset values: all outputs 0, except `ready_o` = 1. HI = LO = 0, state = IDLE, counter = 0.
- Reset asserted mid-operation aborts the operation immediately: HI/LO are cleared, and no `done_o` is produced.

## Configuration
- `ALU_MULDIV_EN` defined: the multiply/divide engine, HI/LO and functs 0x10/0x12/0x18–0x1B are built as above.
- `ALU_MULDIV_EN` undefined:
  - those functs decode as illegal: `illegal_o` pulses, no `done_o`;
  - `busy_o` is tied 0 and `ready_o` tied 1;
  - no HI/LO or counter flops are built.

## Test plan
- ADD 0x7FFFFFFF + 1 and SUB 5 − 5 → `result_o` 0x80000000 at T+1; SUB gives `result_o` 0 and `zero_o` 1.
- SRA `b_i`=0xF0000000, `shamt_i`=4 → 0xFF000000; SRLV with `a_i`=36 → shift by 4 → 0x0F000000.
- MULT −3 × 7, then MFHI and MFLO → `busy_o` high for 33 cycles, `done_o` at T+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 9 / 0 → LO=0xFFFFFFFF, HI=9.
- `valid_i` held high during busy with an ADD → ADD is not accepted until `ready_o` rises; exactly one `done_o` per operation.
- `rst_n` low at cycle 10 of a DIVU → all outputs 0 and `ready_o` 1 immediately; a following MFLO returns 0. Funct 0x3F → `illegal_o` pulse and no `done_o`.
